seq_detect_param: RTL and testbench
===================================

# seq_detect_param

Parametrised serial pattern detector, the next generation of the team's fixed 1010 overlap/non-overlap FSM detectors. It samples a serial bit stream `x` under a qualifier and compares the last N bits against a run-time loadable N-bit pattern. It pulses `z` on each match, with overlap or non-overlap matching selectable per cycle, and keeps a saturating match count. It sits directly on the serial input path as a drop-in replacement for the single-pattern detectors.

## Interface
- `N`, 4, pattern length in bits, 2..32
- `PAT_RST`, 4'b1010, pattern register value after reset, N bits wide
- `CNT_W`, 8, match counter width
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset; one clock domain
- `x`  in  1  serial data bit
- `en`  in  1  `x` valid this cycle; when low, `x` is ignored and history holds
- `overlap`  in  1  1 = overlapping matches allowed, 0 = non-overlapping
- `load`  in  1  load `pattern_in` into the pattern register
- `pattern_in`  in  N  new pattern; MSB = first bit received
- `clr_cnt`  in  1  synchronous clear of `count` and `ovf`
- `z`  out  1  one-cycle match pulse, registered
- `count`  out  CNT_W  number of matches, saturating
- `ovf`  out  1  sticky flag, set when a match arrives while `count` is at maximum

## Operation
- **Registers:** `pat[N-1:0]`, `hist[N-1:0]`, `fill` (0..N, $clog2(N+1) bits), `z`, `count`, `ovf`.
- **Sampling:** on a cycle with `en`=1 and `load`=0:
  - `hist <= {hist[N-2:0], x}`.
  - `fill` increments and saturates at N.
- **Match condition:** true when the post-shift `fill` equals N and `{hist[N-2:0], x}` equals `pat`. On a match:
  - `z <= 1`.
  - With `overlap`=1, `fill` stays at N, so the next match can reuse the trailing bits.
  - With `overlap`=0, `fill <= 0`, so the next match needs N fresh bits.
  - The `overlap` value used is the one sampled in the match cycle. Changing it mid-stream has no other effect.
- **No match:** `z <= 0` on every cycle without a match, including cycles with `en`=0.
- **Load:**
  - `pat <= pattern_in`, `fill <= 0`, `z <= 0`.
  - `x` is discarded that cycle, even if `en`=1; `load` has priority.
  - `count` and `ovf` are unaffected by a load.
- **Counter:**
  - A match increments `count`. At all-ones, `count` holds and `ovf` sets.
  - `clr_cnt` zeroes `count` and `ovf`, and takes priority over a same-cycle increment; that match is lost from the count but still pulses `z`.
- **Reset (asynchronous, `reset`=0):**
  - `pat = PAT_RST`, `hist = 0`, `fill = 0`.
  - Outputs: `z = 0`, `count = 0`, `ovf = 0`.
  - Asserting reset mid-sequence discards any partial match.
- **Pattern content:** there is no special handling for all-zero or all-one patterns; they match like any other value.

## Timing
- Latency: `z` is high for exactly the cycle following the rising edge that sampled the last pattern bit.
- `count` updates on the same edge that raises `z`.
- Non-overlap throughput: at most one match per N qualified cycles.
- Overlap throughput: back-to-back `z` pulses are possible, e.g. pattern 1111 with a continuous stream of 1s.
- Reset deassertion is synchronised externally; the first qualified sample is on the first rising edge after `reset` goes high.
- Gaps with `en`=0 stretch a sequence without breaking it.

## Structure
- No shared package is required. If a shared `seq_pkg` exists, the `PAT_RST` default lives there as a constant.
- One sub-module is natural: `sat_counter`, with parameter `W` and ports `clk`, `reset`, `inc`, `clr`, `q`, `ovf`. It is reusable by other detectors.
- The remainder is a single always block for `pat`, `hist`, `fill` and `z`, plus a combinational compare.

## Test plan
- **Non-overlap 1010:** N=4, default pattern, `overlap`=0, `en`=1, x=1,0,1,0,1,0 → a single `z` pulse after the 4th bit; `count`=1.
- **Overlap 1010:** same stream with `overlap`=1 → `z` pulses after the 4th and 6th bits; `count`=2.
- **Load mid-stream:** after x=1,1, load 4'b0110 with `en`=1 on the same cycle, then x=0,1,1,0 → one `z` after the last 0; the earlier bits do not contribute.
- **Qualifier gaps:** x=1,0,1,0 with `en`=0 cycles between each bit (x toggling randomly in the gaps) → exactly one `z`.
- **Saturation:** `CNT_W`=2, overlap, pattern 1111, eight 1s → `count` goes 1,2,3,3,3; `ovf` rises on the 4th match; then `clr_cnt` → `count`=0, `ovf`=0.
- **Reset mid-sequence:** x=1,0,1, then `reset`=0 asynchronously between edges → `z`, `count` and `ovf` drop to 0 immediately; after release, x=0 alone produces no match.

Source files
------------

// File: rtl/seq_detect_param_pkg.sv
// Shared constants for the serial pattern detectors.
package seq_detect_param_pkg;

  // Classic 1010 pattern loaded after reset by default.
  localparam logic [3:0] PAT_RST_DEFAULT = 4'b1010;

endpackage

// File: rtl/seq_detect_param_sat_counter.sv
// Saturating event counter with sticky overflow flag; clear wins over increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q,
  output logic         ovf
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q   <= '0;
      ovf <= 1'b0;
    end else if (clr) begin
      q   <= '0;
      ovf <= 1'b0;
    end else if (inc) begin
      if (&q) begin
        ovf <= 1'b1;
      end else begin
        q <= q + W'(1);
      end
    end
  end

endmodule

// File: rtl/seq_detect_param.sv
// Parametrised serial pattern detector with run-time loadable pattern,
// selectable overlap matching and a saturating match counter.
module seq_detect_param
  import seq_detect_param_pkg::*;
#(
  parameter int             N       = 4,
  parameter logic [N-1:0]   PAT_RST = N'(PAT_RST_DEFAULT),
  parameter int             CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             x,
  input  logic             en,
  input  logic             overlap,
  input  logic             load,
  input  logic [N-1:0]     pattern_in,
  input  logic             clr_cnt,
  output logic             z,
  output logic [CNT_W-1:0] count,
  output logic             ovf
);

  localparam int            FW        = $clog2(N + 1);
  localparam logic [FW-1:0] FILL_FULL = FW'(N);

  logic [N-1:0]  pat;
  logic [N-1:0]  hist;
  logic [FW-1:0] fill;
  logic [N-1:0]  shifted;
  logic [FW-1:0] fill_inc;
  logic          sample;
  logic          match;

  // fill counts bits received since reset/load/non-overlap match, capped at N.
  always_comb begin
    shifted  = {hist[N-2:0], x};
    fill_inc = (fill == FILL_FULL) ? FILL_FULL : fill + FW'(1);
    sample   = en & ~load;
    match    = sample && (fill_inc == FILL_FULL) && (shifted == pat);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pat  <= PAT_RST;
      hist <= '0;
      fill <= '0;
      z    <= 1'b0;
    end else if (load) begin
      pat  <= pattern_in;
      fill <= '0;
      z    <= 1'b0;
    end else begin
      z <= match;
      if (sample) begin
        hist <= shifted;
        fill <= (match && !overlap) ? '0 : fill_inc;
      end
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (match),
    .clr  (clr_cnt),
    .q    (count),
    .ovf  (ovf)
  );

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed and randomized checks of seq_detect_param against a queue-based model.
module tb_seq_detect_param;

  localparam int N     = 4;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             x = 1'b0;
  logic             en = 1'b0;
  logic             overlap = 1'b0;
  logic             load = 1'b0;
  logic [N-1:0]     pattern_in = '0;
  logic             clr_cnt = 1'b0;
  logic             z;
  logic [CNT_W-1:0] count;
  logic             ovf;

  seq_detect_param #(
    .N      (N),
    .PAT_RST(4'b1010),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .x         (x),
    .en        (en),
    .overlap   (overlap),
    .load      (load),
    .pattern_in(pattern_in),
    .clr_cnt   (clr_cnt),
    .z         (z),
    .count     (count),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int zseen = 0;

  // Reference model: recent bits, bits seen since last restart, counters.
  bit q[$];
  int fresh;
  int m_pat;
  int m_count;
  bit m_ovf;
  bit m_z;

  task automatic check_eq(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    fresh   = 0;
    m_pat   = 4'b1010;
    m_count = 0;
    m_ovf   = 0;
    m_z     = 0;
  endtask

  task automatic model_step(input bit xi, input bit ei, input bit ovi,
                            input bit ldi, input int pi, input bit ci);
    int v;
    m_z = 0;
    if (ldi) begin
      m_pat = pi;
      fresh = 0;
    end else if (ei) begin
      q.push_back(xi);
      if (q.size() > N) void'(q.pop_front());
      if (fresh < N) fresh++;
      v = 0;
      foreach (q[i]) v = (v << 1) | int'(q[i]);
      if (fresh == N && v == m_pat) begin
        m_z = 1;
        if (!ovi) fresh = 0;
      end
    end
    if (ci) begin
      m_count = 0;
      m_ovf   = 0;
    end else if (m_z) begin
      if (m_count == (1 << CNT_W) - 1) m_ovf = 1;
      else m_count++;
    end
  endtask

  // One clock: drive, step model on the edge, compare 1 time unit later.
  task automatic cyc(input bit xi, input bit ei, input bit ovi,
                     input bit ldi, input int pi, input bit ci);
    x = xi; en = ei; overlap = ovi; load = ldi; pattern_in = pi[N-1:0]; clr_cnt = ci;
    @(posedge clk);
    model_step(xi, ei, ovi, ldi, pi, ci);
    #1;
    check_eq("z", int'(z), int'(m_z));
    check_eq("count", int'(count), m_count);
    check_eq("ovf", int'(ovf), int'(m_ovf));
    zseen += int'(z);
  endtask

  task automatic stream(input int bits, input int len, input bit ovi);
    for (int i = len - 1; i >= 0; i--) cyc(bits[i], 1'b1, ovi, 1'b0, 0, 1'b0);
  endtask

  initial begin
    model_reset();
    #12;
    check_eq("rst_z", int'(z), 0);
    check_eq("rst_count", int'(count), 0);
    check_eq("rst_ovf", int'(ovf), 0);
    reset = 1'b1;
    #1;

    // Non-overlap 1010 on default pattern
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    zseen = 0;
    stream(6'b101010, 6, 1'b0);
    check_eq("nonov_pulses", zseen, 1);
    check_eq("nonov_count", int'(count), 1);

    // Overlap 1010
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 4'b1010, 1'b1);
    zseen = 0;
    stream(6'b101010, 6, 1'b1);
    check_eq("ov_pulses", zseen, 2);
    check_eq("ov_count", int'(count), 2);

    // Reset between edges mid-sequence
    stream(3'b101, 3, 1'b0);
    #2 reset = 1'b0;
    model_reset();
    #1;
    check_eq("arst_z", int'(z), 0);
    check_eq("arst_count", int'(count), 0);
    check_eq("arst_ovf", int'(ovf), 0);
    #2 reset = 1'b1;
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    check_eq("arst_nomatch", int'(z), 0);

    // Load mid-stream with en=1 on the load cycle
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 4'b1010, 1'b1);
    zseen = 0;
    stream(2'b11, 2, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 4'b0110, 1'b0);
    stream(4'b0110, 4, 1'b0);
    check_eq("load_pulses", zseen, 1);
    check_eq("load_z_last", int'(z), 1);

    // Qualifier gaps
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 4'b1010, 1'b1);
    zseen = 0;
    for (int i = 3; i >= 0; i--) begin
      cyc(4'b1010 >> i, 1'b1, 1'b0, 1'b0, 0, 1'b0);
      repeat ($urandom_range(1, 3)) cyc(1'($urandom), 1'b0, 1'b0, 1'b0, 0, 1'b0);
    end
    check_eq("gap_pulses", zseen, 1);
    check_eq("gap_count", int'(count), 1);

    // Saturation with pattern 1111
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 4'b1111, 1'b1);
    zseen = 0;
    stream(8'hff, 8, 1'b1);
    check_eq("sat_pulses", zseen, 5);
    check_eq("sat_count", int'(count), 3);
    check_eq("sat_ovf", int'(ovf), 1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b1);
    check_eq("clr_count", int'(count), 0);
    check_eq("clr_ovf", int'(ovf), 0);

    // Randomized traffic with small patterns to make matches frequent
    for (int i = 0; i < 600; i++) begin
      cyc(1'($urandom), ($urandom_range(0, 9) < 7), 1'($urandom),
          ($urandom_range(0, 29) == 0), int'($urandom_range(0, 15)),
          ($urandom_range(0, 39) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
